// File: rtl/maxmin_scan_ctrl.sv
// maxmin_scan_ctrl: frame scanner tracking max/min value and index,
// comparing each element nibble-wise over two cycles (LO then HI).
// Ports: iClk/iRst (sync active-high); iStart/iLen start a frame
// (iLen=0 means 16); iData/iValid/oReady element handshake;
// oMax/oMin/oMaxIdx/oMinIdx results; oCmp last-vs-max (100 gt,
// 010 eq, 001 lt); oBusy not idle; oDone one-cycle final pulse.
// Option: define SIGNED_CMP_EN for two's complement comparison.
module maxmin_scan_ctrl (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [3:0] iLen,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oMax,
  output logic [7:0] oMin,
  output logic [3:0] oMaxIdx,
  output logic [3:0] oMinIdx,
  output logic [2:0] oCmp,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [2:0] {
    IDLE, FIRST, NEXT, CMP_LO, CMP_HI, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] elem_q, elem_d;
  logic [7:0] max_q, max_d;
  logic [7:0] min_q, min_d;
  logic [3:0] maxidx_q, maxidx_d;
  logic [3:0] minidx_q, minidx_d;
  logic [2:0] cmp_q, cmp_d;
  logic [2:0] lomax_q, lomax_d;
  logic [2:0] lomin_q, lomin_d;

  function automatic logic [2:0] cmp4(
    input logic [3:0] a,
    input logic [3:0] b
  );
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  logic [3:0] hi_e, hi_mx, hi_mn;
  logic [2:0] hmax, hmin, rmax, rmin;
  logic       last;

  always_comb begin
    hi_e  = elem_q[7:4];
    hi_mx = max_q[7:4];
    hi_mn = min_q[7:4];
`ifdef SIGNED_CMP_EN
    // Flipping the sign bit maps two's complement onto unsigned order.
    hi_e[3]  = ~elem_q[7];
    hi_mx[3] = ~max_q[7];
    hi_mn[3] = ~min_q[7];
`endif
    hmax = cmp4(hi_e, hi_mx);
    hmin = cmp4(hi_e, hi_mn);
    // Equal high nibbles defer to the low-nibble result.
    rmax = (hmax == 3'b010) ? lomax_q : hmax;
    rmin = (hmin == 3'b010) ? lomin_q : hmin;
    // len 0 wraps to 15, giving a 16-element frame.
    last = (idx_q == (len_q - 4'd1));
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    elem_d   = elem_q;
    max_d    = max_q;
    min_d    = min_q;
    maxidx_d = maxidx_q;
    minidx_d = minidx_q;
    cmp_d    = cmp_q;
    lomax_d  = lomax_q;
    lomin_d  = lomin_q;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          len_d   = iLen;
          cnt_d   = 4'd0;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (iValid) begin
          max_d    = iData;
          min_d    = iData;
          maxidx_d = 4'd0;
          minidx_d = 4'd0;
          cmp_d    = 3'b000;
          cnt_d    = 4'd1;
          state_d  = (len_q == 4'd1) ? DONE : NEXT;
        end
      end
      NEXT: begin
        if (iValid) begin
          elem_d  = iData;
          idx_d   = cnt_q;
          cnt_d   = cnt_q + 4'd1;
          state_d = CMP_LO;
        end
      end
      CMP_LO: begin
        lomax_d = cmp4(elem_q[3:0], max_q[3:0]);
        lomin_d = cmp4(elem_q[3:0], min_q[3:0]);
        state_d = CMP_HI;
      end
      CMP_HI: begin
        cmp_d = rmax;
        if (rmax == 3'b100) begin
          max_d    = elem_q;
          maxidx_d = idx_q;
        end
        if (rmin == 3'b001) begin
          min_d    = elem_q;
          minidx_d = idx_q;
        end
        state_d = last ? DONE : NEXT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      elem_q   <= '0;
      max_q    <= '0;
      min_q    <= '0;
      maxidx_q <= '0;
      minidx_q <= '0;
      cmp_q    <= '0;
      lomax_q  <= '0;
      lomin_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      elem_q   <= elem_d;
      max_q    <= max_d;
      min_q    <= min_d;
      maxidx_q <= maxidx_d;
      minidx_q <= minidx_d;
      cmp_q    <= cmp_d;
      lomax_q  <= lomax_d;
      lomin_q  <= lomin_d;
    end
  end

  assign oReady  = (state_q == FIRST) || (state_q == NEXT);
  assign oBusy   = (state_q != IDLE);
  assign oDone   = (state_q == DONE);
  assign oMax    = max_q;
  assign oMin    = min_q;
  assign oMaxIdx = maxidx_q;
  assign oMinIdx = minidx_q;
  assign oCmp    = cmp_q;

endmodule

// File: doc/maxmin_scan_ctrl.md
MAXMIN_SCAN_CTRL -- requirements
Module: maxmin_scan_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL provide port iClk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-003 SHALL provide port iRst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide port iStart, input, 1 bit: frame start request; sampled only in IDLE.
REQ-005 SHALL provide port iLen, input, 4 bits: frame length, latched on accepted iStart; 0 means 16 elements.
REQ-006 SHALL provide port iData, input, 8 bits: element value.
REQ-007 SHALL provide port iValid, input, 1 bit: iData is valid.
REQ-008 SHALL provide port oReady, output, 1 bit: the block accepts iData this cycle.
REQ-009 SHALL provide port oMax, output, 8 bits: running or final maximum.
REQ-010 SHALL provide port oMin, output, 8 bits: running or final minimum.
REQ-011 SHALL provide port oMaxIdx, output, 4 bits: zero-based element index of oMax.
REQ-012 SHALL provide port oMinIdx, output, 4 bits: zero-based element index of oMin.
REQ-013 SHALL provide port oCmp, output, 3 bits: last element vs previous max, encoded 100 greater, 010 equal, 001 less, 000 none.
REQ-014 SHALL provide port oBusy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL provide port oDone, output, 1 bit: one-cycle pulse when the frame result is final.

Function
REQ-016 SHALL implement the states IDLE, FIRST, NEXT, CMP_LO, CMP_HI and DONE.
REQ-017 SHALL, in IDLE, on iStart=1, latch iLen, clear the element counter and go to FIRST; iStart SHALL be ignored in all other states.
REQ-018 SHALL drive oReady=1 only in FIRST and NEXT; a transfer occurs on a rising edge where iValid=1 and oReady=1.
REQ-019 SHALL, on a transfer in FIRST, load oMax=oMin=iData and oMaxIdx=oMinIdx=0, and set oCmp=000; if the frame length is 1 it SHALL go to DONE, otherwise to NEXT.
REQ-020 SHALL, on a transfer in NEXT, register the element and its index and go to CMP_LO.
REQ-021 SHALL, in CMP_LO, compare the element's low nibble against the low nibbles of oMax and oMin, and register both 3-bit results.
REQ-022 SHALL, in CMP_HI, compare the high nibbles; the result is the high-nibble result unless the nibbles are equal, in which case it is the registered low result.
REQ-023 SHALL, in CMP_HI, update oMax/oMaxIdx only on strictly greater and oMin/oMinIdx only on strictly less, so ties keep the earlier index; it SHALL also write oCmp.
REQ-024 SHALL leave CMP_HI to DONE if the element was the last of the frame, otherwise to NEXT.
REQ-025 SHALL achieve a throughput of one element per 3 cycles after the first.
REQ-026 SHALL produce oDone 1 cycle after the last CMP_HI; for a 1-element frame, 1 cycle after the transfer.
REQ-027 SHALL pulse oDone=1 for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL hold oMax, oMin, oMaxIdx, oMinIdx and oCmp stable from DONE until the next accepted iStart.
REQ-029 SHALL wait indefinitely in FIRST or NEXT while iValid=0, with no timeout.
REQ-030 SHALL leave iData ignored outside transfer cycles.

Reset
REQ-031 SHALL, on iRst=1 at a rising edge, take effect in any state, including mid-frame, and override iStart and iValid.
REQ-032 SHALL, on reset, go to IDLE and clear oMax, oMin, oMaxIdx, oMinIdx, oCmp, oBusy, oDone, oReady and the element counter to 0.

Configuration
REQ-033 SHALL, with SIGNED_CMP_EN defined, compare elements as 8-bit two's complement by inverting bit 7 of both operands at the high-nibble stage only.
REQ-034 SHALL, with SIGNED_CMP_EN undefined, compare elements as unsigned 8-bit; this is the default.

Verification
REQ-035 SHALL cover: iLen=4, data 0x12,0x7F,0x05,0x7F (unsigned) -> oMax=0x7F, oMaxIdx=1, oMin=0x05, oMinIdx=2, last oCmp=010, one oDone pulse.
REQ-036 SHALL cover: iLen=1, data 0xA5 -> oMax=oMin=0xA5, both indices 0, oDone 1 cycle after the transfer.
REQ-037 SHALL cover: iLen=0, 16 elements 0x00..0x0F in ascending order -> oMax=0x0F, oMaxIdx=15, oMin=0x00, oMinIdx=0; oReady asserted once every 3 cycles.
REQ-038 SHALL cover: SIGNED_CMP_EN defined, data 0x80,0x7F,0xFF -> oMax=0x7F, oMaxIdx=1, oMin=0x80, oMinIdx=0; the same data with the macro undefined -> oMax=0xFF, oMin=0x7F.
REQ-039 SHALL cover: iValid held low 5 cycles mid-frame, then iRst asserted during CMP_LO -> IDLE next cycle, all outputs 0, no oDone pulse.
REQ-040 SHALL cover: iStart pulsed while oBusy=1 -> ignored, and the frame result is unchanged.
